// File: rtl/mul_m4_wb_buffer_pkg.sv
// Shared multiply-pipeline definitions: datapath widths, instruction-type
// encodings and the depth of the M4 write-back buffer.
package mul_m4_wb_buffer_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int INSTR_TYPE_SZ   = 3;
  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int MUL_WB_DEPTH    = 2;

  // Instruction-type encodings carried alongside every result.
  typedef enum logic [INSTR_TYPE_SZ-1:0] {
    INSTR_ALU    = 3'd0,
    INSTR_BRANCH = 3'd1,
    INSTR_LOAD   = 3'd2,
    INSTR_STORE  = 3'd3,
    INSTR_MUL    = 3'd4,
    INSTR_DIV    = 3'd5
  } instr_type_e;

  // Width of an entry counter that must be able to hold 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mul_m4_wb_buffer_result_fifo.sv
// Generic in-order FIFO with synchronous flush. Read data is presented
// combinationally from the head entry; flush wins over push and pop.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the array is reset so the head outputs read as zero out of reset;
    // this costs a reset net per storage bit, kept because DEPTH is tiny.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/mul_m4_wb_buffer.sv
// M4 stage of the multiply pipeline: buffers results from the M3/M4 register
// and offers them in order to the shared ROB write port via req/grant.
module mul_m4_wb_buffer
  import mul_m4_wb_buffer_pkg::*;
#(
  parameter int WORD_SIZE       = mul_m4_wb_buffer_pkg::WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = mul_m4_wb_buffer_pkg::INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = mul_m4_wb_buffer_pkg::ROB_ENTRY_WIDTH,
  parameter int DEPTH           = MUL_WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [INSTR_TYPE_SZ-1:0]     in_instruction_type,
  input  logic [WORD_SIZE-1:0]         in_pc,
  input  logic [WORD_SIZE-1:0]         in_result,
  input  logic [ROB_ENTRY_WIDTH-1:0]   in_rob_id,
  output logic                         stall_out,
  output logic                         wb_valid,
  input  logic                         wb_grant,
  output logic [INSTR_TYPE_SZ-1:0]     wb_instruction_type,
  output logic [WORD_SIZE-1:0]         wb_pc,
  output logic [WORD_SIZE-1:0]         wb_result,
  output logic [ROB_ENTRY_WIDTH-1:0]   wb_rob_id,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PAYLOAD_W = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WIDTH;

  logic [PAYLOAD_W-1:0] wr_payload;
  logic [PAYLOAD_W-1:0] rd_payload;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Stall is taken from registered fullness only, so a full buffer refuses
  // input even in a cycle where it also drains; M3/M4 simply retries.
  assign stall_out = fifo_full;
  assign wb_valid  = !fifo_empty;
  assign push      = in_valid && !stall_out && !flush;
  assign pop       = wb_valid && wb_grant && !flush;

  assign wr_payload = {in_instruction_type, in_pc, in_result, in_rob_id};
  assign {wb_instruction_type, wb_pc, wb_result, wb_rob_id} = rd_payload;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_payload),
    .rd_data (rd_payload),
    .count   (occupancy),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
